// File: rtl/uart_tx_queue_if.sv
// rtl/uart_tx_queue_if.sv - producer/transmitter signal bundle for uart_tx_queue
interface uart_tx_queue_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clr_ovf;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          arm_err;
  logic          TxD_start;
  logic [7:0]    TxD_data;
  logic          TxD_busy;

  modport slave (
    input  wr_en, wr_data, clr_ovf, TxD_busy,
    output full, empty, count, overflow, arm_err, TxD_start, TxD_data
  );

  modport master (
    output wr_en, wr_data, clr_ovf, TxD_busy,
    input  full, empty, count, overflow, arm_err, TxD_start, TxD_data
  );
endinterface

// File: rtl/uart_fifo_sync.sv
// rtl/uart_fifo_sync.sv - DEPTH x WIDTH synchronous FIFO with occupancy count
module uart_fifo_sync #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte queue that launches one TxD_start per byte, paced on TxD_busy
module uart_tx_queue #(
  parameter int DEPTH       = 16,
  parameter int ARM_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_queue_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(ARM_TIMEOUT + 1);
  localparam logic [TW-1:0] ARM_LAST = TW'(ARM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    ARM    = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] arm_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_data;
  logic          pop;
  logic          start_q;
  logic [7:0]    data_q;
  logic          overflow_q;
  logic          arm_err_q;

  // Pop only on the IDLE->LAUNCH decision, which sees the registered count (no bypass).
  assign pop = (state == IDLE) && !fifo_empty && !bus.TxD_busy;

  uart_fifo_sync #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      arm_cnt    <= '0;
      start_q    <= 1'b0;
      data_q     <= 8'h00;
      overflow_q <= 1'b0;
      arm_err_q  <= 1'b0;
    end else begin
      if (bus.wr_en && fifo_full) overflow_q <= 1'b1;
      else if (bus.clr_ovf)       overflow_q <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            data_q  <= fifo_data;
            start_q <= 1'b1;
            state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          start_q <= 1'b0;
          arm_cnt <= '0;
          state   <= ARM;
        end
        ARM: begin
          if (bus.TxD_busy) begin
            state <= DRAIN;
          end else if (arm_cnt == ARM_LAST) begin
            arm_err_q <= 1'b1;
            state     <= IDLE;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!bus.TxD_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.count     = fifo_count;
  assign bus.overflow  = overflow_q;
  assign bus.arm_err   = arm_err_q;
  assign bus.TxD_start = start_q;
  assign bus.TxD_data  = data_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - directed self-checking bench for uart_tx_queue
module tb_uart_tx_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_queue_if #(.DEPTH(16)) bus ();

  uart_tx_queue #(.DEPTH(16), .ARM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Transmitter model: busy rises the cycle after TxD_start and holds 11 cycles.
  logic model_busy = 1'b0;
  logic hold_busy = 1'b0;
  logic never_busy = 1'b0;
  int   tx_cnt = 0;

  always @(posedge clk) begin
    if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) model_busy <= 1'b0;
    end else if (bus.TxD_start && !never_busy) begin
      model_busy <= 1'b1;
      tx_cnt     <= 11;
    end
  end

  assign bus.TxD_busy = model_busy | hold_busy;

  logic [7:0] log_q[$];

  always @(negedge clk) begin
    if (!rst && bus.TxD_start) begin
      log_q.push_back(bus.TxD_data);
      check_eq("start_while_busy", 32'(bus.TxD_busy), 32'd0);
    end
  end

  task automatic push_byte(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_launches(input int target, input int bound);
    for (int k = 0; k < bound && log_q.size() < target; k++) @(negedge clk);
    check_eq("launch_count", 32'(log_q.size()), 32'(target));
  endtask

  int base;

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_ovf = 1'b0;
    #1;
    check_eq("rst_count", 32'(bus.count), 32'd0);
    check_eq("rst_empty", 32'(bus.empty), 32'd1);
    check_eq("rst_full", 32'(bus.full), 32'd0);
    check_eq("rst_overflow", 32'(bus.overflow), 32'd0);
    check_eq("rst_arm_err", 32'(bus.arm_err), 32'd0);
    check_eq("rst_start", 32'(bus.TxD_start), 32'd0);
    check_eq("rst_data", 32'(bus.TxD_data), 32'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: single byte, two-edge latency
    push_byte(8'hA5);
    check_eq("t1_count_after_push", 32'(bus.count), 32'd1);
    check_eq("t1_no_start_yet", 32'(bus.TxD_start), 32'd0);
    @(negedge clk);
    check_eq("t1_start", 32'(bus.TxD_start), 32'd1);
    check_eq("t1_data", 32'(bus.TxD_data), 32'hA5);
    repeat (25) @(negedge clk);
    check_eq("t1_launches", 32'(log_q.size()), 32'd1);
    check_eq("t1_count", 32'(bus.count), 32'd0);
    check_eq("t1_empty", 32'(bus.empty), 32'd1);

    // 2: fill while transmitter busy
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check_eq("t2_full", 32'(bus.full), 32'd1);
    check_eq("t2_count", 32'(bus.count), 32'd16);
    check_eq("t2_overflow", 32'(bus.overflow), 32'd0);

    // 3: overflow set/clear, set wins over clear
    push_byte(8'hFF);
    check_eq("t3_overflow_set", 32'(bus.overflow), 32'd1);
    check_eq("t3_count_kept", 32'(bus.count), 32'd16);
    repeat (2) @(negedge clk);
    check_eq("t3_overflow_sticky", 32'(bus.overflow), 32'd1);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    check_eq("t3_overflow_clr", 32'(bus.overflow), 32'd0);
    bus.clr_ovf = 1'b1;
    push_byte(8'hFF);
    bus.clr_ovf = 1'b0;
    check_eq("t3_set_wins", 32'(bus.overflow), 32'd1);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;

    base = log_q.size();
    hold_busy = 1'b0;
    wait_launches(base + 16, 800);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 16; i++) check_eq($sformatf("t2_order_%0d", i), 32'(log_q[base+i]), 32'(i));
    check_eq("t2_drained", 32'(bus.count), 32'd0);
    check_eq("t2_overflow_end", 32'(bus.overflow), 32'd0);

    // 4: push coincident with pop at count=5
    hold_busy = 1'b1;
    base = log_q.size();
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
    check_eq("t4_count_pre", 32'(bus.count), 32'd5);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h15;
    hold_busy   = 1'b0;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check_eq("t4_count_same", 32'(bus.count), 32'd5);
    check_eq("t4_start", 32'(bus.TxD_start), 32'd1);
    check_eq("t4_first", 32'(bus.TxD_data), 32'h10);
    wait_launches(base + 6, 400);
    repeat (20) @(negedge clk);
    check_eq("t4_last", 32'(log_q[base+5]), 32'h15);

    // 5: busy never rises -> arm_err after 4 ARM cycles
    hold_busy = 1'b1;
    push_byte(8'h20);
    push_byte(8'h21);
    never_busy = 1'b1;
    hold_busy  = 1'b0;
    @(negedge clk);
    check_eq("t5_start0", 32'(bus.TxD_start), 32'd1);
    check_eq("t5_data0", 32'(bus.TxD_data), 32'h20);
    repeat (4) @(negedge clk);
    check_eq("t5_arm_err_early", 32'(bus.arm_err), 32'd0);
    @(negedge clk);
    check_eq("t5_arm_err", 32'(bus.arm_err), 32'd1);
    @(negedge clk);
    check_eq("t5_start1", 32'(bus.TxD_start), 32'd1);
    check_eq("t5_data1", 32'(bus.TxD_data), 32'h21);
    repeat (10) @(negedge clk);
    check_eq("t5_arm_err_sticky", 32'(bus.arm_err), 32'd1);
    never_busy = 1'b0;

    // 6: async reset during DRAIN
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'h30 + 8'(i));
    hold_busy = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t6_count_drain", 32'(bus.count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_count", 32'(bus.count), 32'd0);
    check_eq("t6_rst_empty", 32'(bus.empty), 32'd1);
    check_eq("t6_rst_arm_err", 32'(bus.arm_err), 32'd0);
    check_eq("t6_rst_start", 32'(bus.TxD_start), 32'd0);
    check_eq("t6_rst_data", 32'(bus.TxD_data), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    base = log_q.size();
    repeat (30) @(negedge clk);
    check_eq("t6_no_launch", 32'(log_q.size()), 32'(base));
    push_byte(8'h5A);
    wait_launches(base + 1, 40);
    check_eq("t6_new_byte", 32'(log_q[log_q.size()-1]), 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
